// File: rtl/dna_pkg.sv
// Shared constants and types for the DNA search pipeline front end.
package dna_pkg;
   localparam int DEF_KEY_BASES  = 32;
   localparam int DEF_DATA_BASES = 512;

   localparam logic [1:0] BASE_A = 2'b00;
   localparam logic [1:0] BASE_C = 2'b01;
   localparam logic [1:0] BASE_G = 2'b10;
   localparam logic [1:0] BASE_T = 2'b11;

   localparam logic [7:0] ASCII_A_UC = 8'h41;
   localparam logic [7:0] ASCII_C_UC = 8'h43;
   localparam logic [7:0] ASCII_G_UC = 8'h47;
   localparam logic [7:0] ASCII_T_UC = 8'h54;
   localparam logic [7:0] ASCII_A_LC = 8'h61;
   localparam logic [7:0] ASCII_C_LC = 8'h63;
   localparam logic [7:0] ASCII_G_LC = 8'h67;
   localparam logic [7:0] ASCII_T_LC = 8'h74;

   typedef enum logic [1:0] {LOAD_KEY, LOAD_DATA, PRESENT} load_state_t;
endpackage

// File: rtl/dna_base_encoder.sv
// ASCII nucleotide to 2-bit code; case-insensitive, flags anything that is not ACGT.
module dna_base_encoder
   import dna_pkg::*;
(
   input  logic [7:0] in_char,
   output logic [1:0] code,
   output logic       is_valid
);
   always_comb begin
      code     = BASE_A;
      is_valid = 1'b1;
      case (in_char)
         ASCII_A_UC, ASCII_A_LC: code = BASE_A;
         ASCII_C_UC, ASCII_C_LC: code = BASE_C;
         ASCII_G_UC, ASCII_G_LC: code = BASE_G;
         ASCII_T_UC, ASCII_T_LC: code = BASE_T;
         default:                is_valid = 1'b0;
      endcase
   end
endmodule

// File: rtl/dna_sequence_loader.sv
// Packs a character stream into a search key followed by a reference data window
// and presents the pair to the search stage over a valid/ready handshake.
module dna_sequence_loader
   import dna_pkg::*;
#(
   parameter int KEY_BASES  = DEF_KEY_BASES,
   parameter int DATA_BASES = DEF_DATA_BASES
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    restart,
   input  logic [7:0]              in_char,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [2*KEY_BASES-1:0]  key,
   output logic [2*DATA_BASES-1:0] data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    error
);
   localparam int CNT_W = $clog2(DATA_BASES) + 1;
   localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_BASES - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BASES - 1);

   load_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       code;
   logic             code_ok;
   logic             xfer;

   dna_base_encoder u_enc (
      .in_char  (in_char),
      .code     (code),
      .is_valid (code_ok)
   );

   assign xfer = in_valid && in_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= LOAD_KEY;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         error     <= 1'b0;
         key       <= '0;
         data      <= '0;
      end else if (restart) begin
         // key/data are left as-is; the next full load overwrites them
         state     <= LOAD_KEY;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         error     <= 1'b0;
      end else begin
         case (state)
            LOAD_KEY: begin
               if (xfer && !code_ok) error <= 1'b1;
               if (xfer && code_ok) begin
                  key <= {key[2*KEY_BASES-3:0], code};
                  if (cnt == KEY_LAST) begin
                     state <= LOAD_DATA;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            LOAD_DATA: begin
               if (xfer && !code_ok) error <= 1'b1;
               if (xfer && code_ok) begin
                  data <= {data[2*DATA_BASES-3:0], code};
                  if (cnt == DATA_LAST) begin
                     state     <= PRESENT;
                     cnt       <= '0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            PRESENT: begin
               if (out_ready) begin
                  state     <= LOAD_KEY;
                  cnt       <= '0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  error     <= 1'b0;
               end
            end
            default: begin
               state     <= LOAD_KEY;
               cnt       <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dna_sequence_loader.sv
// Directed bench for dna_sequence_loader with a small packing model for key/data.
module tb_dna_sequence_loader;
   logic          clock = 1'b0;
   logic          reset, restart, in_valid, in_ready, out_valid, out_ready, error;
   logic [7:0]    in_char;
   logic [63:0]   key;
   logic [1023:0] data;

   logic [63:0]   ekey;
   logic [1023:0] edata;
   int            kn, dn;
   int            n_chk = 0;
   int            n_err = 0;

   dna_sequence_loader dut (
      .clock     (clock),
      .reset     (reset),
      .restart   (restart),
      .in_char   (in_char),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .key       (key),
      .data      (data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .error     (error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] enc(input logic [7:0] c);
      case (c)
         "A", "a": return 3'b100;
         "C", "c": return 3'b101;
         "G", "g": return 3'b110;
         "T", "t": return 3'b111;
         default:  return 3'b000;
      endcase
   endfunction

   // Update the packing model for a character the loader is expected to consume.
   task automatic model(input logic [7:0] c);
      logic [2:0] e;
      e = enc(c);
      if (e[2]) begin
         if (kn < 32) begin
            ekey = {ekey[61:0], e[1:0]};
            kn++;
         end else begin
            edata = {edata[1021:0], e[1:0]};
            dn++;
         end
      end
   endtask

   task automatic send(input logic [7:0] c);
      in_char  = c;
      in_valid = 1'b1;
      model(c);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic new_load();
      kn = 0;
      dn = 0;
   endtask

   function automatic logic [7:0] pat(input int i);
      logic [7:0] s [4];
      s = '{"A", "c", "G", "t"};
      return s[(i * 5 + (i >> 2)) & 3];
   endfunction

   initial begin
      logic [7:0] acgt [4];
      acgt = '{"A", "C", "G", "T"};
      reset = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_char = 8'h00;
      ekey = '0; edata = '0; kn = 0; dn = 0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_key", key, 64'd0);
      chk("rst_data_zero", 64'(data === '0), 64'd1);

      // Test A: ACGT key, all-A data
      new_load();
      for (int i = 0; i < 32; i++) send(acgt[i % 4]);
      chk("a_key_early", key, 64'h1B1B1B1B1B1B1B1B);
      for (int i = 0; i < 511; i++) send("A");
      chk("a_not_yet_valid", 64'(out_valid), 64'd0);
      send("A");
      chk("a_out_valid", 64'(out_valid), 64'd1);
      chk("a_in_ready", 64'(in_ready), 64'd0);
      chk("a_key", key, 64'h1B1B1B1B1B1B1B1B);
      chk("a_data_zero", 64'(data === '0), 64'd1);
      chk("a_error", 64'(error), 64'd0);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      chk("a_hs_out_valid", 64'(out_valid), 64'd0);
      chk("a_hs_in_ready", 64'(in_ready), 64'd1);

      // Test B: lowercase t key with an 'N' after the 10th char; out_ready held high
      new_load();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) send("t");
      chk("b_err_before", 64'(error), 64'd0);
      send("N");
      chk("b_err_after_n", 64'(error), 64'd1);
      for (int i = 0; i < 22; i++) send("t");
      chk("b_key", key, 64'hFFFFFFFFFFFFFFFF);
      for (int i = 0; i < 512; i++) send("c");
      chk("b_out_valid", 64'(out_valid), 64'd1);
      chk("b_err_present", 64'(error), 64'd1);
      chk("b_key_final", key, 64'hFFFFFFFFFFFFFFFF);
      chk("b_data", 64'(data === {512{2'b01}}), 64'd1);
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      chk("b_err_cleared", 64'(error), 64'd0);
      chk("b_hs_out_valid", 64'(out_valid), 64'd0);

      // Test C: in_valid toggling, then a 20-cycle stall in PRESENT
      new_load();
      for (int i = 0; i < 544; i++) begin
         send(pat(i));
         @(posedge clock);
         #1;
      end
      chk("c_out_valid", 64'(out_valid), 64'd1);
      chk("c_model_counts", 64'(kn * 1000 + dn), 64'd32512);
      in_char  = "G";
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("c_stall_in_ready", 64'(in_ready), 64'd0);
         chk("c_stall_key", key, ekey);
         chk("c_stall_data", 64'(data === edata), 64'd1);
         @(posedge clock);
         #1;
      end
      chk("c_still_valid", 64'(out_valid), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      chk("c_hs_in_ready", 64'(in_ready), 64'd1);

      // Test D: restart after 100 data bases, with a char offered the same cycle
      new_load();
      for (int i = 0; i < 132; i++) send(acgt[(i / 3) % 4]);
      send("x");
      chk("d_err_set", 64'(error), 64'd1);
      in_char  = "T";
      in_valid = 1'b1;
      restart  = 1'b1;
      @(posedge clock);
      #1;
      restart  = 1'b0;
      in_valid = 1'b0;
      chk("d_rs_out_valid", 64'(out_valid), 64'd0);
      chk("d_rs_in_ready", 64'(in_ready), 64'd1);
      chk("d_rs_error", 64'(error), 64'd0);
      new_load();
      for (int i = 0; i < 543; i++) send(pat(i + 7));
      chk("d_not_yet_valid", 64'(out_valid), 64'd0);
      send(pat(550));
      chk("d_out_valid", 64'(out_valid), 64'd1);
      chk("d_key", key, ekey);
      chk("d_data", 64'(data === edata), 64'd1);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;

      // Test E: asynchronous reset mid-cycle during LOAD_DATA
      new_load();
      for (int i = 0; i < 82; i++) send("G");
      send("Z");
      chk("e_err_set", 64'(error), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("e_out_valid", 64'(out_valid), 64'd0);
      chk("e_in_ready", 64'(in_ready), 64'd1);
      chk("e_key", key, 64'd0);
      chk("e_data_zero", 64'(data === '0), 64'd1);
      chk("e_error", 64'(error), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/dna_sequence_loader.md
# dna_sequence_loader

Upstream stage of the DNA search pipeline: accepts a stream of ASCII nucleotide characters over a valid/ready handshake, encodes each to 2 bits, and packs the first KEY_BASES characters into the search key and the following DATA_BASES characters into the reference data window. When both are complete it presents the packed `key` and `data` words with a valid/ready handshake to the comparator-based search stage. It then feeds that stage's `data`/`key` inputs directly.

## Interface
- `KEY_BASES`, 32, bases per key (key width = 2*KEY_BASES = 64)
- `DATA_BASES`, 512, bases per data window (data width = 2*DATA_BASES = 1024)

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `restart`  in  1  synchronous abort; discards partial load
- `in_char`  in  8  ASCII nucleotide
- `in_valid`  in  1  `in_char` valid
- `in_ready`  out  1  loader accepts `in_char`
- `key`  out  2*KEY_BASES  packed key, first base in MSBs
- `data`  out  2*DATA_BASES  packed data, first base in MSBs
- `out_valid`  out  1  `key`/`data` complete and stable
- `out_ready`  in  1  search stage consumes the pair
- `error`  out  1  sticky: a non-ACGT character was received

## Operation
- Encoding: A/a=00, C/c=01, G/g=10, T/t=11. Any other byte is invalid.
- Transfer = `in_valid && in_ready`. Valid transfer shifts its code into the active register from the LSB end: `key <= {key[2*KEY_BASES-3:0], code}` (likewise `data`). After a full load the first base therefore sits at the MSBs.
- Invalid transfer: the byte is consumed, nothing is shifted, the counter does not advance, and `error` is set.
- States:
  - LOAD_KEY: `in_ready`=1. The KEY_BASES-th valid base moves to LOAD_DATA.
  - LOAD_DATA: `in_ready`=1. The DATA_BASES-th valid base moves to PRESENT.
  - PRESENT: `in_ready`=0, `out_valid`=1. `out_valid && out_ready` moves to LOAD_KEY.
- Base counter: one counter, width clog2(DATA_BASES)+1. It resets to 0 on every state entry.
- `key`/`data` keep their values after the handshake until shifted by the next load. `error` stays sticky until the PRESENT handshake completes, `restart`, or `reset`.
- `restart` has priority over every transfer in the same cycle. It forces LOAD_KEY, counter 0, `out_valid`=0, `error`=0. `key`/`data` are not cleared.

## Timing
- Reset values: state LOAD_KEY, `in_ready`=1, `out_valid`=0, `error`=0, `key`=0, `data`=0, counter 0.
- Reset asserted mid-load or during PRESENT returns all of the above immediately, asynchronously.
- The register update happens at the edge that samples the transfer. An invalid character raises `error` in the cycle after it is sampled.
- The KEY_BASES-th key base is sampled at edge N. At edge N+1 the loader accepts the first data base (state is LOAD_DATA with no gap).
- The final data base is sampled at edge M. From just after edge M: `out_valid`=1, `in_ready`=0, `key`/`data` final. There are no bubble cycles.
- `out_valid` holds until `out_ready` is sampled high. It drops, and `in_ready` rises, after that edge.
- `out_ready` outside PRESENT is ignored.
- Throughput: one base per cycle. There is a minimum of 1 PRESENT cycle per load.

## Structure
- Package `dna_pkg`:
  - 2-bit base codes `BASE_A`, `BASE_C`, `BASE_G`, `BASE_T`
  - ASCII constants
  - loader state enum (LOAD_KEY, LOAD_DATA, PRESENT)
  - default KEY_BASES/DATA_BASES
- Sub-module `dna_base_encoder`: combinational, maps `in_char` to {`code[1:0]`, `is_valid`}. It is shared with later stream-side blocks.

## Test plan
- Key: 32 chars "ACGT" repeated; data: 512 × 'A'. Required: after the last char, `out_valid`=1, `key`=64'h1B1B1B1B1B1B1B1B, `data`=0, `error`=0. `out_ready`=1 for one cycle → `out_valid`=0, `in_ready`=1 next cycle.
- Key: lowercase "t" × 32. Required: `key`=64'hFFFFFFFFFFFFFFFF. Also insert an 'N' after the 10th key char; it is not counted, still 32 valid chars are needed, `error`=1. `error` clears only after the PRESENT handshake.
- `in_valid` toggling every other cycle, plus `out_ready` held low for 20 cycles in PRESENT. Required: `in_ready`=0 and `key`/`data` constant throughout, no characters lost, and the final words match a software model.
- `restart` pulsed after 100 data bases with `in_valid`=1 the same cycle. Required: that char is dropped, the state is LOAD_KEY, and a full fresh 544-char load is needed before `out_valid`.
- `reset` driven low asynchronously mid-cycle during LOAD_DATA. Required: `out_valid`=0, `in_ready`=1, `key`=`data`=0, `error`=0 immediately, before the next edge.
